// File: rtl/alu_uart_ctrl.sv
// Byte-framed ALU controller: collects operand A, operand B and an opcode from a
// receiver, drives an external ALU, and hands the result to a transmitter.
module alu_uart_ctrl #(
  parameter int SIZEDATA = 8,
  parameter int SIZEOP   = 6,
  parameter int TIMEOUT  = 1000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [SIZEDATA-1:0] RX_DATA,
  input  logic                RX_VALID,
  input  logic [SIZEDATA-1:0] ALU_RESULT,
  output logic [SIZEDATA-1:0] ALU_A,
  output logic [SIZEDATA-1:0] ALU_B,
  output logic [SIZEOP-1:0]   ALU_OP,
  output logic [SIZEDATA-1:0] TX_DATA,
  output logic                TX_START,
  input  logic                TX_DONE,
  output logic                BUSY,
  output logic                ERROR,
  output logic                DROP
);

  localparam int              CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  idle_cnt;
  logic [SIZEOP-1:0] rx_op;
  logic              op_legal;
  logic              timed_out;

  assign rx_op     = RX_DATA[SIZEOP-1:0];
  assign timed_out = (idle_cnt == CNT_MAX) && !RX_VALID;

  always_comb begin
    op_legal = 1'b0;
    case (rx_op)
      SIZEOP'('h20), SIZEOP'('h22), SIZEOP'('h24), SIZEOP'('h25),
      SIZEOP'('h26), SIZEOP'('h27), SIZEOP'('h02), SIZEOP'('h03): op_legal = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) state <= WAIT_A;
    else        state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    TX_START   = 1'b0;
    BUSY       = (state != WAIT_A);
    case (state)
      WAIT_A:  if (RX_VALID) state_next = WAIT_B;
      WAIT_B: begin
        if (RX_VALID)       state_next = WAIT_OP;
        else if (timed_out) state_next = WAIT_A;
      end
      WAIT_OP: begin
        if (RX_VALID)       state_next = op_legal ? EXEC : WAIT_A;
        else if (timed_out) state_next = WAIT_A;
      end
      EXEC:    state_next = SEND;
      SEND: begin
        TX_START   = 1'b1;
        state_next = WAIT_TX;
      end
      WAIT_TX: if (TX_DONE) state_next = WAIT_A;
      default: state_next = WAIT_A;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_OP   <= SIZEOP'('h20);
      TX_DATA  <= '0;
      ERROR    <= 1'b0;
      DROP     <= 1'b0;
      idle_cnt <= '0;
    end else begin
      DROP <= RX_VALID && (state == EXEC || state == SEND || state == WAIT_TX);
      case (state)
        WAIT_A: begin
          idle_cnt <= '0;
          if (RX_VALID) begin
            ALU_A <= RX_DATA;
            ERROR <= 1'b0;
          end
        end
        WAIT_B: begin
          if (RX_VALID) begin
            ALU_B    <= RX_DATA;
            idle_cnt <= '0;
          end else if (timed_out) begin
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        WAIT_OP: begin
          if (RX_VALID) begin
            idle_cnt <= '0;
            // An illegal opcode aborts the frame but leaves the last good opcode on the ALU.
            if (op_legal) ALU_OP <= rx_op;
            else          ERROR  <= 1'b1;
          end else if (timed_out) begin
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        EXEC:    TX_DATA <= ALU_RESULT;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl: drives byte frames, models the ALU, and
// scoreboards every transmitted result against values predicted from the sent bytes.
module tb_alu_uart_ctrl;

  localparam int TO = 20;

  logic       CLK;
  logic       RESET;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic [7:0] ALU_RESULT;
  logic [7:0] ALU_A, ALU_B, TX_DATA;
  logic [5:0] ALU_OP;
  logic       TX_START, TX_DONE, BUSY, ERROR, DROP;

  int         checks;
  int         errors;
  int         tx_count;
  int         exp_tx;
  logic [7:0] sb[$];
  logic [5:0] last_op;

  alu_uart_ctrl #(.SIZEDATA(8), .SIZEOP(6), .TIMEOUT(TO)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .RX_DATA    (RX_DATA),
    .RX_VALID   (RX_VALID),
    .ALU_RESULT (ALU_RESULT),
    .ALU_A      (ALU_A),
    .ALU_B      (ALU_B),
    .ALU_OP     (ALU_OP),
    .TX_DATA    (TX_DATA),
    .TX_START   (TX_START),
    .TX_DONE    (TX_DONE),
    .BUSY       (BUSY),
    .ERROR      (ERROR),
    .DROP       (DROP)
  );

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    logic [2:0] sh;
    sh = b[2:0];
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return a >> sh;
      6'h03:   return 8'($signed(a) >>> sh);
      default: return 8'h00;
    endcase
  endfunction

  assign ALU_RESULT = alu_model(ALU_A, ALU_B, ALU_OP);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
  endtask

  task automatic wait_tx(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (TX_START) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check(tag, found, 1'b1);
  endtask

  task automatic pulse_done();
    TX_DONE = 1'b1;
    tick();
    TX_DONE = 1'b0;
    check("idle_after_done", BUSY, 1'b0);
  endtask

  // Scoreboard consumer: every TX_START must match the oldest predicted result.
  always @(negedge CLK) begin
    if (RESET && TX_START) begin
      tx_count++;
      if (sb.size() == 0) check("tx_unexpected", TX_START, 1'b0);
      else                check("tx_data", TX_DATA, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, b, opb;
    logic [5:0] ops[5];
    checks   = 0;
    errors   = 0;
    tx_count = 0;
    exp_tx   = 0;
    ops      = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h02};

    // Reset with activity on the inputs, which must be ignored.
    RESET    = 1'b0;
    RX_DATA  = 8'h55;
    RX_VALID = 1'b1;
    TX_DONE  = 1'b1;
    repeat (3) tick();
    check("rst_alu_a", ALU_A, 8'h00);
    check("rst_alu_b", ALU_B, 8'h00);
    check("rst_alu_op", ALU_OP, 6'h20);
    check("rst_tx_data", TX_DATA, 8'h00);
    check("rst_tx_start", TX_START, 1'b0);
    check("rst_error", ERROR, 1'b0);
    check("rst_drop", DROP, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    RX_VALID = 1'b0;
    TX_DONE  = 1'b0;
    RESET    = 1'b1;
    tick();

    // ADD frame with exact latency.
    send_byte(8'h05);
    check("add_a", ALU_A, 8'h05);
    check("add_busy", BUSY, 1'b1);
    send_byte(8'h03);
    check("add_b", ALU_B, 8'h03);
    sb.push_back(8'h08);
    exp_tx++;
    send_byte(8'h20);
    check("add_op", ALU_OP, 6'h20);
    check("exec_no_start", TX_START, 1'b0);
    tick();
    check("send_start", TX_START, 1'b1);
    check("send_data", TX_DATA, 8'h08);
    tick();
    check("waittx_no_start", TX_START, 1'b0);
    check("waittx_busy", BUSY, 1'b1);
    pulse_done();
    last_op = 6'h20;

    // Illegal opcode aborts without transmission.
    send_byte(8'h10);
    send_byte(8'h01);
    send_byte(8'h3F);
    check("illegal_error", ERROR, 1'b1);
    check("illegal_busy", BUSY, 1'b0);
    check("illegal_op_held", ALU_OP, last_op);
    repeat (4) tick();
    check("illegal_no_tx", tx_count, exp_tx);
    send_byte(8'h07);
    check("error_cleared", ERROR, 1'b0);
    check("new_a", ALU_A, 8'h07);

    // SUB frame, then a byte arriving during WAIT_TX is dropped.
    send_byte(8'h04);
    sb.push_back(8'h03);
    exp_tx++;
    send_byte(8'h22);
    wait_tx("sub_start");
    tick();
    send_byte(8'hAA);
    check("drop_pulse", DROP, 1'b1);
    check("drop_a_held", ALU_A, 8'h07);
    check("drop_busy", BUSY, 1'b1);
    tick();
    check("drop_one_cycle", DROP, 1'b0);
    check("drop_tx_held", TX_DATA, 8'h03);
    pulse_done();
    last_op = 6'h22;

    // SRA with upper opcode bits set, plus a byte dropped during EXEC.
    send_byte(8'h90);
    send_byte(8'h02);
    sb.push_back(8'hE4);
    exp_tx++;
    send_byte(8'hC3);
    check("sra_op", ALU_OP, 6'h03);
    send_byte(8'h5A);
    check("exec_drop", DROP, 1'b1);
    check("exec_drop_a", ALU_A, 8'h90);
    wait_tx("sra_start");
    repeat (3) tick();
    check("sra_single_start", tx_count, exp_tx);
    pulse_done();
    last_op = 6'h03;

    // Remaining opcodes with random operands and random ignored upper bits.
    foreach (ops[i]) begin
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      opb = {2'($urandom_range(0, 3)), ops[i]};
      send_byte(a);
      send_byte(b);
      sb.push_back(alu_model(a, b, ops[i]));
      exp_tx++;
      send_byte(opb);
      check("loop_op", ALU_OP, ops[i]);
      wait_tx("loop_start");
      tick();
      pulse_done();
      last_op = ops[i];
    end

    // Idle timeout in WAIT_B.
    send_byte(8'h11);
    repeat (TO - 1) tick();
    check("to_not_yet", BUSY, 1'b1);
    tick();
    check("to_idle", BUSY, 1'b0);
    check("to_no_tx", tx_count, exp_tx);
    send_byte(8'h22);
    check("to_new_a", ALU_A, 8'h22);
    check("to_error_kept", ERROR, 1'b0);

    // A byte in the final idle cycle wins over the timeout; then time out in WAIT_OP.
    repeat (TO - 1) tick();
    send_byte(8'h33);
    check("to_rx_wins_b", ALU_B, 8'h33);
    check("to_rx_wins_busy", BUSY, 1'b1);
    repeat (TO - 1) tick();
    check("to_op_not_yet", BUSY, 1'b1);
    tick();
    check("to_op_idle", BUSY, 1'b0);
    check("to_op_held", ALU_OP, last_op);
    check("to_op_no_tx", tx_count, exp_tx);

    // Reset while waiting for the transmitter.
    send_byte(8'h05);
    send_byte(8'h03);
    sb.push_back(8'h08);
    exp_tx++;
    send_byte(8'h20);
    wait_tx("rst_frame_start");
    tick();
    RESET = 1'b0;
    tick();
    check("mid_rst_alu_a", ALU_A, 8'h00);
    check("mid_rst_alu_b", ALU_B, 8'h00);
    check("mid_rst_alu_op", ALU_OP, 6'h20);
    check("mid_rst_tx_data", TX_DATA, 8'h00);
    check("mid_rst_tx_start", TX_START, 1'b0);
    check("mid_rst_error", ERROR, 1'b0);
    check("mid_rst_drop", DROP, 1'b0);
    check("mid_rst_busy", BUSY, 1'b0);
    RESET = 1'b1;
    pulse_done();
    send_byte(8'h66);
    check("post_rst_a", ALU_A, 8'h66);
    check("post_rst_busy", BUSY, 1'b1);

    repeat (3) tick();
    check("sb_empty", sb.size(), 0);
    check("tx_total", tx_count, exp_tx);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_uart_ctrl.md
ALU_UART_CTRL -- requirements
Module: alu_uart_ctrl

Interface
REQ-001 Parameter SIZEDATA, default 8, operand/result/RX/TX byte width.
REQ-002 Parameter SIZEOP, default 6, ALU opcode width.
REQ-003 Parameter TIMEOUT, default 1000, maximum idle cycles between bytes of one frame.
REQ-004 CLK  in  1  single clock; all state changes on rising edge.
REQ-005 RESET  in  1  synchronous, active-low reset.
REQ-006 RX_DATA  in  SIZEDATA  received byte, qualified by RX_VALID.
REQ-007 RX_VALID  in  1  one-cycle strobe, RX_DATA valid.
REQ-008 ALU_RESULT  in  SIZEDATA  combinational result from ALU.
REQ-009 ALU_A  out  SIZEDATA  operand A to ALU.
REQ-010 ALU_B  out  SIZEDATA  operand B to ALU.
REQ-011 ALU_OP  out  SIZEOP  opcode to ALU.
REQ-012 TX_DATA  out  SIZEDATA  result byte to transmitter, stable from TX_START until TX_DONE.
REQ-013 TX_START  out  1  one-cycle request to transmit TX_DATA.
REQ-014 TX_DONE  in  1  one-cycle strobe, transmitter finished.
REQ-015 BUSY  out  1  high in any state other than WAIT_A.
REQ-016 ERROR  out  1  sticky: last frame had illegal opcode.
REQ-017 DROP  out  1  one-cycle pulse: an RX byte was discarded.

Function
REQ-018 States SHALL be WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
REQ-019 WAIT_A + RX_VALID: ALU_A <= RX_DATA, ERROR <= 0, go WAIT_B.
REQ-020 WAIT_B + RX_VALID: ALU_B <= RX_DATA, go WAIT_OP.
REQ-021 WAIT_OP + RX_VALID: opcode = RX_DATA[SIZEOP-1:0]; upper bits ignored.
REQ-022 Legal opcodes: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x02 SRL, 0x03 SRA.
REQ-023 Legal opcode: ALU_OP <= opcode, go EXEC; illegal: ERROR <= 1, ALU_OP unchanged, go WAIT_A, no transmission.
REQ-024 EXEC lasts exactly one cycle: TX_DATA <= ALU_RESULT at its end, go SEND.
REQ-025 SEND lasts one cycle with TX_START = 1, go WAIT_TX; TX_START SHALL be 0 in every other state.
REQ-026 WAIT_TX + TX_DONE: go WAIT_A; TX_DONE in any other state ignored.
REQ-027 Latency: opcode accepted at edge k -> EXEC cycle k+1, TX_START high in cycle k+2 only.
REQ-028 ALU_A, ALU_B, ALU_OP SHALL hold their values until overwritten by a later accepted byte.
REQ-029 RX_VALID in EXEC, SEND or WAIT_TX: byte discarded, DROP = 1 next cycle, state and registers unchanged.
REQ-030 Idle counter: cleared on every accepted byte and on entry to WAIT_A; increments each cycle in WAIT_B/WAIT_OP without RX_VALID.
REQ-031 Counter reaching TIMEOUT-1 without RX_VALID: go WAIT_A, no TX_START, ERROR unchanged; RX_VALID in that same cycle wins (byte accepted, no timeout).
REQ-032 Counter SHALL be wide enough for TIMEOUT-1 and SHALL never wrap; inactive in WAIT_A, EXEC, SEND, WAIT_TX.

Reset
REQ-033 RESET = 0 at a rising edge: state WAIT_A; ALU_A, ALU_B, TX_DATA = 0; ALU_OP = 0x20; TX_START, ERROR, DROP, BUSY = 0; counter = 0.
REQ-034 Reset SHALL override all inputs in the same cycle, including mid-frame and in WAIT_TX; RX_VALID/TX_DONE during reset ignored.

Verification
REQ-035 Bytes 0x05, 0x03, 0x20 (ALU model adds) -> ALU_A=0x05, ALU_B=0x03, ALU_OP=0x20, TX_START one cycle 2 cycles after opcode edge, TX_DATA=0x08; TX_DONE -> BUSY=0.
REQ-036 Bytes 0x10, 0x01, 0x3F -> ERROR=1, no TX_START, BUSY=0; next byte 0x07 -> ERROR=0, ALU_A=0x07.
REQ-037 Bytes 0x90, 0x02, 0xC3 -> ALU_OP=0x03 (SRA, upper bits ignored), TX_START asserted once.
REQ-038 Byte 0x11 then silence TIMEOUT cycles -> WAIT_A, BUSY=0, no TX_START; then 0x22 -> ALU_A=0x22.
REQ-039 RX_VALID with 0xAA during WAIT_TX -> DROP pulses once, ALU_A unchanged, TX_DATA held; TX_DONE returns to WAIT_A.
REQ-040 RESET=0 during WAIT_TX -> next cycle all outputs at REQ-033 values; later TX_DONE has no effect.
